// File: rtl/weave_pkg.sv
// Shared state encoding and playback mode constants for the weave sequencer.
package weave_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PLAIN    = 2'd0;
    localparam mode_t MODE_INVERT   = 2'd1;
    localparam mode_t MODE_ROTATE   = 2'd2;
    localparam mode_t MODE_PINGPONG = 2'd3;

endpackage

// File: rtl/weave_rowmem.sv
// Pattern row store: DEPTH x CHANNELS registers, synchronous write, combinational read.
module weave_rowmem #(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [CHANNELS-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [CHANNELS-1:0] rdata
);

    logic [CHANNELS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/weave_seq.sv
// Weave pattern sequencer: stores rows, plays them back with per-pass transforms.
// Define WEAVE_SEQ_ROTATE_EN to build the mode-2 rotator; otherwise mode 2 acts as mode 0.
module weave_seq
    import weave_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 8,
    parameter int DIV_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    input  logic [CHANNELS-1:0]      load_data,
    output logic                     load_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic [DIV_W-1:0]         div,
    output logic [CHANNELS-1:0]      row_out,
    output logic                     row_strobe,
    output logic [$clog2(DEPTH)-1:0] row_idx,
    output logic [7:0]               pass_cnt,
    output logic                     busy
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       count;
    logic [IW-1:0]       wr_ptr;
    mode_t               mode_l, mode_eff;
    logic [DIV_W-1:0]    div_l, div_cnt;
    logic                dir, ndir;
    logic [IW-1:0]       nidx, last_idx;
    logic [7:0]          npass;
    logic [CHANNELS-1:0] rd_data, xform;
    logic                idle, start_ok, wr_en, due;

    assign idle       = (state == ST_IDLE);
    assign busy       = (state == ST_RUN);
    assign load_ready = idle && (count < CW'(DEPTH));
    assign wr_en      = load_valid && load_ready && !clear;
    assign start_ok   = idle && start && !stop && !clear && (count != '0);
    assign due        = (div_cnt == div_l);
    assign last_idx   = IW'(count - CW'(1));

`ifdef WEAVE_SEQ_ROTATE_EN
    assign mode_eff = mode_l;
`else
    assign mode_eff = (mode_l == MODE_ROTATE) ? MODE_PLAIN : mode_l;
`endif

    weave_rowmem #(.CHANNELS(CHANNELS), .DEPTH(DEPTH), .AW(IW)) u_rowmem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(load_data),
        .raddr(nidx),
        .rdata(rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_RUN;
            ST_RUN:  if (stop)     state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next row index/pass; in IDLE this addresses row 0 for the first strobe.
    always_comb begin
        nidx  = row_idx;
        npass = pass_cnt;
        ndir  = dir;
        if (idle) begin
            nidx  = '0;
            npass = '0;
            ndir  = 1'b0;
        end else if (mode_eff == MODE_PINGPONG) begin
            if (count == CW'(1)) begin
                nidx  = '0;
                npass = pass_cnt + 8'd1;
            end else if (!dir) begin
                nidx = row_idx + IW'(1);
                if (nidx == last_idx) begin
                    ndir  = 1'b1;
                    npass = pass_cnt + 8'd1;
                end
            end else begin
                nidx = row_idx - IW'(1);
                if (nidx == '0) begin
                    ndir  = 1'b0;
                    npass = pass_cnt + 8'd1;
                end
            end
        end else if (row_idx == last_idx) begin
            nidx  = '0;
            npass = pass_cnt + 8'd1;
        end else begin
            nidx = row_idx + IW'(1);
        end
    end

`ifdef WEAVE_SEQ_ROTATE_EN
    int unsigned         rot_sh;
    logic [CHANNELS-1:0] rot_row;
    assign rot_sh  = 32'(npass) % CHANNELS;
    assign rot_row = (rd_data << rot_sh) | (rd_data >> (CHANNELS - rot_sh));
`endif

    always_comb begin
        xform = rd_data;
        case (mode_eff)
            MODE_INVERT: xform = rd_data ^ {CHANNELS{npass[0]}};
`ifdef WEAVE_SEQ_ROTATE_EN
            MODE_ROTATE: xform = rot_row;
`endif
            default: xform = rd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            wr_ptr     <= '0;
            mode_l     <= MODE_PLAIN;
            div_l      <= '0;
            div_cnt    <= '0;
            dir        <= 1'b0;
            row_idx    <= '0;
            pass_cnt   <= '0;
            row_out    <= '0;
            row_strobe <= 1'b0;
        end else begin
            row_strobe <= 1'b0;
            if (idle) begin
                if (clear) begin
                    count  <= '0;
                    wr_ptr <= '0;
                end else if (wr_en) begin
                    count  <= count + CW'(1);
                    wr_ptr <= wr_ptr + IW'(1);
                end
                // Pass 0 leaves every transform as identity, so row 0 goes out raw.
                if (start_ok) begin
                    mode_l     <= mode;
                    div_l      <= div;
                    div_cnt    <= '0;
                    dir        <= 1'b0;
                    row_idx    <= '0;
                    pass_cnt   <= '0;
                    row_out    <= rd_data;
                    row_strobe <= 1'b1;
                end
            end else if (!stop) begin
                if (due) begin
                    div_cnt    <= '0;
                    row_idx    <= nidx;
                    pass_cnt   <= npass;
                    dir        <= ndir;
                    row_out    <= xform;
                    row_strobe <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_weave_seq.sv
// Directed self-checking bench for weave_seq (default parameters).
module tb_weave_seq;

    logic       clk = 1'b0;
    logic       rst_n, load_valid, clear, start, stop;
    logic [7:0] load_data;
    logic [1:0] mode;
    logic [3:0] div;
    logic       load_ready, row_strobe, busy;
    logic [7:0] row_out, pass_cnt;
    logic [2:0] row_idx;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] t1_row [5] = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02};
    logic [7:0] t1_pas [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    logic [2:0] t1_idx [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
    logic [7:0] t2_row [5] = '{8'h02, 8'h04, 8'hFE, 8'hFD, 8'hFB};
    logic [7:0] t2_pas [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
`ifdef WEAVE_SEQ_ROTATE_EN
    logic [7:0] t3_row [4] = '{8'h81, 8'h03, 8'h03, 8'h06};
`else
    logic [7:0] t3_row [4] = '{8'h81, 8'h03, 8'h81, 8'h03};
`endif
    logic [7:0] t4_mem [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [2:0] t4_idx [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    logic [7:0] t4_pas [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};

    always #5 clk = ~clk;

    weave_seq #(.CHANNELS(8), .DEPTH(8), .DIV_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .clear     (clear),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .div       (div),
        .row_out   (row_out),
        .row_strobe(row_strobe),
        .row_idx   (row_idx),
        .pass_cnt  (pass_cnt),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic write_row(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic stop_clear();
        stop = 1'b1;
        tick();
        stop  = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [3:0] d);
        mode  = m;
        div   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; clear = 1'b0;
        start = 1'b0; stop = 1'b0; mode = '0; div = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_strobe", row_strobe, 0);
        chk("rst_row", row_out, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_idx", row_idx, 0);
        chk("rst_ready", load_ready, 1);
        rst_n = 1'b1;

        // mode 0, div 0: strobe every cycle, wrap increments pass
        write_row(8'h01); write_row(8'h02); write_row(8'h04);
        start_run(2'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("m0_strobe", row_strobe, 1);
            chk("m0_row", row_out, t1_row[i]);
            chk("m0_idx", row_idx, t1_idx[i]);
            chk("m0_pass", pass_cnt, t1_pas[i]);
        end
        chk("run_ready", load_ready, 0);
        chk("run_busy", busy, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_strobe", row_strobe, 0);
        chk("stop_row", row_out, 8'h02);
        chk("stop_idx", row_idx, 1);
        chk("stop_pass", pass_cnt, 1);

        // mode 1, div 2: strobe every third cycle, odd pass inverted, div latched
        start_run(2'd1, 4'd2);
        div = 4'd0;
        chk("m1_first_strobe", row_strobe, 1);
        chk("m1_first_row", row_out, 8'h01);
        chk("m1_first_pass", pass_cnt, 0);
        for (int k = 0; k < 5; k++) begin
            tick(); chk("m1_gap_a", row_strobe, 0);
            tick(); chk("m1_gap_b", row_strobe, 0);
            tick();
            chk("m1_strobe", row_strobe, 1);
            chk("m1_row", row_out, t2_row[k]);
            chk("m1_pass", pass_cnt, t2_pas[k]);
        end
        stop_clear();

        // start with empty store is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_start_busy", busy, 0);
        chk("empty_start_strobe", row_strobe, 0);
        tick();
        chk("empty_start_busy2", busy, 0);

        // mode 2: rotate by pass (or plain without the rotator)
        write_row(8'h81); write_row(8'h03);
        start_run(2'd2, 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("m2_row", row_out, t3_row[i]);
            chk("m2_pass", pass_cnt, i / 2);
        end
        stop_clear();

        // mode 3: ping-pong over 4 rows
        for (int i = 0; i < 4; i++) write_row(t4_mem[i]);
        start_run(2'd3, 4'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk("m3_idx", row_idx, t4_idx[i]);
            chk("m3_pass", pass_cnt, t4_pas[i]);
            chk("m3_row", row_out, t4_mem[t4_idx[i]]);
        end
        stop_clear();

        // overfill: 9th write dropped
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i + 1);
            chk("fill_ready", load_ready, (i < 8) ? 1 : 0);
            tick();
        end
        load_valid = 1'b0;
        chk("full_ready", load_ready, 0);
        start_run(2'd0, 4'd0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            chk("full_idx", row_idx, i % 8);
            chk("full_row", row_out, (i % 8) + 1);
            chk("full_pass", pass_cnt, i / 8);
        end
        tick(); tick();

        // reset in the middle of a run
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_row", row_out, 0);
        chk("midrst_pass", pass_cnt, 0);
        chk("midrst_strobe", row_strobe, 0);
        chk("midrst_idx", row_idx, 0);
        chk("midrst_ready", load_ready, 1);

        // start+stop together stays idle; then single-row ping-pong
        write_row(8'h55);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_strobe", row_strobe, 0);
        start_run(2'd3, 4'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("one_idx", row_idx, 0);
            chk("one_row", row_out, 8'h55);
            chk("one_pass", pass_cnt, i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
